fix_field_tokenizer: RTL and testbench
======================================

# fix_field_tokenizer

Streaming FIX tokenizer: consumes the raw byte stream one byte per cycle and splits it into SOH-terminated `tag=value` fields. Each field goes into an output FIFO with a ready/valid handshake. It tracks message boundaries (tag 8 … tag 10) and verifies the trailing modulo-256 checksum. It generalises the parser front end with configurable tag/value widths, an input valid/ready handshake, output buffering and malformed-field detection, and feeds the message store and query logic downstream.

## Interface
- `TAG_BYTES`, 4, maximum tag length in ASCII digits.
- `VALUE_BYTES`, 32, maximum value length in bytes.
- `FIFO_DEPTH`, 8, output field FIFO entries (power of two, ≥2).

- `clk`  in  1  clock; one clock domain.
- `rst`  in  1  reset, asynchronous, active-high.
- `data_i`  in  8  stream byte.
- `data_valid_i`  in  1  `data_i` valid.
- `data_ready_o`  out  1  byte accepted when `data_valid_i & data_ready_o`.
- `field_tag_o`  out  8*TAG_BYTES  tag ASCII, right-aligned, zero-padded (tag "10" = 32'h00003130).
- `field_value_o`  out  8*VALUE_BYTES  value bytes, right-aligned (last byte in [7:0]), zero-padded.
- `field_len_o`  out  $clog2(VALUE_BYTES+1)  value byte count.
- `field_sof_o`  out  1  field is tag "8" (start of message).
- `field_eom_o`  out  1  field is tag "10" (end of message).
- `field_valid_o`  out  1  FIFO head valid.
- `field_ready_i`  in  1  pop FIFO head when `field_valid_o & field_ready_i`.
- `error_o`  out  1  one-cycle pulse on a malformed field.
- `checksum_o`  out  8  computed checksum of the last completed message.
- `checksum_valid_o`  out  1  one-cycle pulse when `checksum_o`/`checksum_ok_o` update.
- `checksum_ok_o`  out  1  received tag-10 value equals `checksum_o`.

## Operation
- FSM states: IDLE, TAG, VALUE, DISCARD. All transitions occur only on accepted bytes.
- IDLE (between messages):
  - SOH is ignored and not summed.
  - A digit enters TAG and is the first summed byte of the message.
  - Any other byte goes to DISCARD with an `error_o` pulse.
- TAG:
  - A digit shifts into the tag register.
  - `=` with a tag length ≥1 goes to VALUE.
  - A non-digit, a (TAG_BYTES+1)th digit, `=` with an empty tag, or SOH goes to DISCARD with an `error_o` pulse. For the SOH case, go to TAG instead of DISCARD.
- VALUE:
  - A non-SOH byte shifts into the value register and `len` increments.
  - Byte number VALUE_BYTES+1 goes to DISCARD with an `error_o` pulse.
  - SOH pushes {tag, value, len, sof, eom} into the FIFO, then goes to TAG (or IDLE if the tag was "10").
- DISCARD: bytes are dropped until SOH, which returns to TAG. Discarded bytes are still summed. A malformed field never enters the FIFO.
- Checksum:
  - The running sum (8-bit wrap) covers every accepted byte from the message's first byte onward.
  - At the first tag byte of each field, the current sum is latched as `field_start_sum`.
  - When tag "10" completes (at `=`), `field_start_sum` is captured as the computed checksum.
  - The tag-10 value must be exactly 3 ASCII digits. They are decoded decimal (0–999) and compared to the computed checksum.
  - On the tag-10 terminating SOH: `checksum_o` ← computed, `checksum_ok_o` ← match, `checksum_valid_o` pulses, and the sum clears.
  - A tag-10 value that is not 3 digits gives `checksum_ok_o` = 0.
- A tag "8" field seen mid-message (no prior tag 10) restarts the sum from that field's first byte.

## Timing
- `data_ready_o` = FIFO not full.
- A push on the SOH accepted in cycle N makes `field_valid_o` high in N+1 if the FIFO was empty.
- Pop and push in the same cycle are both performed. When full, no push is possible, so `data_ready_o` rises the cycle after a pop.
- `error_o` and `checksum_valid_o` are registered and pulse in the cycle after the triggering byte.
- Reset values:
  - `data_ready_o` = 1.
  - All other outputs 0.
  - FSM = IDLE, FIFO empty, sum = 0.
- Reset mid-message discards the partial field and FIFO contents. There is no output activity until the next byte is accepted after reset.

## Configuration
- `FIX_CHECKSUM_EN` defined: full checksum logic as above.
- `FIX_CHECKSUM_EN` undefined:
  - No sum or decode logic.
  - `checksum_o` = 0, `checksum_valid_o` = 0, `checksum_ok_o` = 0.
  - Tag-10 fields are still tokenised with `field_eom_o` = 1.

## Structure
- Package `fix_pkg`:
  - Constants: `FIX_SOH` = 8'h01, `FIX_EQ` = 8'h3D, `FIX_TAG_BEGIN` = 8'h38, `FIX_TAG_CHECKSUM` = 16'h3130.
  - Typedef: `fix_tok_state_e` enum.
  - Digit-test function.
- Sub-module `fix_field_fifo`: synchronous FIFO parametrised on entry width and `FIFO_DEPTH`, with full/empty flags.

## Test plan
- "8=A␁10=183␁" with `field_ready_i` = 1 → field 1: tag 32'h38, value 8'h41, len 1, sof = 1. Field 2: tag 32'h3130, value 24'h313833, eom = 1. Then `checksum_o` = 8'hB7 and `checksum_ok_o` = 1.
- Same message with "10=184" → `checksum_o` = 8'hB7 and `checksum_ok_o` = 0. Without `FIX_CHECKSUM_EN` → `checksum_valid_o` never asserts.
- Tag "12345=X␁" (TAG_BYTES = 4) → one `error_o` pulse, no push. The next valid field is tokenised normally.
- VALUE_BYTES = 4, "55=ABCDE␁" → `error_o` pulse, FIFO unchanged. "55=ABCD␁" → value 32'h41424344, len 4.
- `field_ready_i` = 0, then feed FIFO_DEPTH+1 fields → `data_ready_o` falls after the 8th push and the stream stalls. One pop → `data_ready_o` rises the next cycle and no field is lost.
- Assert `rst` mid-value → all outputs at reset values and FIFO empty. A fresh message afterwards produces the correct checksum.

Source files
------------

// File: rtl/fix_pkg.sv
// fix_pkg: shared constants, state type and byte helpers
// for the FIX field tokenizer.
package fix_pkg;

  localparam logic [7:0]  FIX_SOH          = 8'h01;
  localparam logic [7:0]  FIX_EQ           = 8'h3D;
  localparam logic [7:0]  FIX_TAG_BEGIN    = 8'h38;
  localparam logic [15:0] FIX_TAG_CHECKSUM = 16'h3130;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_TAG,
    ST_VALUE,
    ST_DISCARD
  } fix_tok_state_e;

  function automatic logic fix_is_digit(input logic [7:0] b);
    return (b >= 8'h30) && (b <= 8'h39);
  endfunction

endpackage

// File: rtl/fix_field_fifo.sv
// fix_field_fifo: synchronous FIFO for tokenised fields,
// wrap-bit pointers give the full/empty flags.
module fix_field_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_q, wr_d;
  logic [AW:0]      rd_q, rd_d;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) &&
                   (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign data_o  = mem_q[rd_q[AW-1:0]];

  // Pointer advance on push/pop.
  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (do_push) wr_d = wr_q + ONE;
    if (do_pop)  rd_d = rd_q + ONE;
  end

  // Pointer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // Storage array; contents are qualified by the pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/fix_field_tokenizer.sv
// fix_field_tokenizer: splits a FIX byte stream into tag=value fields.
// Checksum tracking is built only when FIX_CHECKSUM_EN is defined.
module fix_field_tokenizer
  import fix_pkg::*;
#(
  parameter int TAG_BYTES   = 4,
  parameter int VALUE_BYTES = 32,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [7:0]                         data_i,
  input  logic                               data_valid_i,
  output logic                               data_ready_o,
  output logic [8*TAG_BYTES-1:0]             field_tag_o,
  output logic [8*VALUE_BYTES-1:0]           field_value_o,
  output logic [$clog2(VALUE_BYTES+1)-1:0]   field_len_o,
  output logic                               field_sof_o,
  output logic                               field_eom_o,
  output logic                               field_valid_o,
  input  logic                               field_ready_i,
  output logic                               error_o,
  output logic [7:0]                         checksum_o,
  output logic                               checksum_valid_o,
  output logic                               checksum_ok_o
);

  localparam int TW  = 8 * TAG_BYTES;
  localparam int VW  = 8 * VALUE_BYTES;
  localparam int LW  = $clog2(VALUE_BYTES + 1);
  localparam int TLW = $clog2(TAG_BYTES + 1);
  localparam int EW  = TW + VW + LW + 2;

  fix_tok_state_e state_q, state_d;
  logic [TW-1:0]  tag_q, tag_d;
  logic [TLW-1:0] tlen_q, tlen_d;
  logic [VW-1:0]  val_q, val_d;
  logic [LW-1:0]  vlen_q, vlen_d;
  logic           err_q, err_d;
  logic           push;
  logic           acc;
  logic           full;
  logic           empty;
  logic [EW-1:0]  head;
  logic           is_dig, is_eq, is_soh;
  logic           tag_is_8, tag_is_10;

  assign acc       = data_valid_i && !full;
  assign is_dig    = fix_is_digit(data_i);
  assign is_eq     = (data_i == FIX_EQ);
  assign is_soh    = (data_i == FIX_SOH);
  assign tag_is_8  = (tag_q == TW'(FIX_TAG_BEGIN));
  assign tag_is_10 = (tag_q == TW'(FIX_TAG_CHECKSUM));

  // Field tokenizer: classifies each accepted byte.
  always_comb begin
    state_d = state_q;
    tag_d   = tag_q;
    tlen_d  = tlen_q;
    val_d   = val_q;
    vlen_d  = vlen_q;
    err_d   = 1'b0;
    push    = 1'b0;
    if (acc) begin
      unique case (state_q)
        ST_IDLE: begin
          if (is_dig) begin
            state_d = ST_TAG;
            tag_d   = TW'(data_i);
            tlen_d  = TLW'(1);
          end else if (!is_soh) begin
            state_d = ST_DISCARD;
            err_d   = 1'b1;
          end
        end
        ST_TAG: begin
          unique case (1'b1)
            is_dig: begin
              if (tlen_q == TLW'(TAG_BYTES)) begin
                state_d = ST_DISCARD;
                err_d   = 1'b1;
              end else begin
                tag_d  = {tag_q[TW-9:0], data_i};
                tlen_d = tlen_q + TLW'(1);
              end
            end
            is_eq: begin
              if (tlen_q != '0) begin
                state_d = ST_VALUE;
                val_d   = '0;
                vlen_d  = '0;
              end else begin
                state_d = ST_DISCARD;
                err_d   = 1'b1;
              end
            end
            is_soh: begin
              err_d  = 1'b1;
              tag_d  = '0;
              tlen_d = '0;
            end
            default: begin
              state_d = ST_DISCARD;
              err_d   = 1'b1;
            end
          endcase
        end
        ST_VALUE: begin
          if (is_soh) begin
            push    = 1'b1;
            tag_d   = '0;
            tlen_d  = '0;
            state_d = tag_is_10 ? ST_IDLE : ST_TAG;
          end else if (vlen_q == LW'(VALUE_BYTES)) begin
            state_d = ST_DISCARD;
            err_d   = 1'b1;
          end else begin
            val_d  = {val_q[VW-9:0], data_i};
            vlen_d = vlen_q + LW'(1);
          end
        end
        ST_DISCARD: begin
          if (is_soh) begin
            state_d = ST_TAG;
            tag_d   = '0;
            tlen_d  = '0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Tokenizer state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      tag_q   <= '0;
      tlen_q  <= '0;
      val_q   <= '0;
      vlen_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tag_q   <= tag_d;
      tlen_q  <= tlen_d;
      val_q   <= val_d;
      vlen_q  <= vlen_d;
      err_q   <= err_d;
    end
  end

  fix_field_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .data_i  ({tag_q, val_q, vlen_q, tag_is_8, tag_is_10}),
    .pop_i   (field_ready_i),
    .data_o  (head),
    .full_o  (full),
    .empty_o (empty)
  );

  assign data_ready_o  = !full;
  assign field_valid_o = !empty;
  assign error_o       = err_q;
  assign {field_tag_o, field_value_o, field_len_o,
          field_sof_o, field_eom_o} = empty ? '0 : head;

`ifdef FIX_CHECKSUM_EN
  logic [7:0] sum_q, sum_d;
  logic [7:0] fss_q, fss_d;
  logic [7:0] calc_q, calc_d;
  logic [7:0] cks_q, cks_d;
  logic       ok_q, ok_d;
  logic       cv_q, cv_d;
  logic [9:0] dec;
  logic       dec_ok;

  assign dec = 10'(val_q[19:16]) * 10'd100 +
               10'(val_q[11:8]) * 10'd10 +
               10'(val_q[3:0]);
  assign dec_ok = (vlen_q == LW'(3)) &&
                  fix_is_digit(val_q[23:16]) &&
                  fix_is_digit(val_q[15:8]) &&
                  fix_is_digit(val_q[7:0]);

  // Running message sum, field-start snapshot and tag-10 verdict.
  always_comb begin
    sum_d  = sum_q;
    fss_d  = fss_q;
    calc_d = calc_q;
    cks_d  = cks_q;
    ok_d   = ok_q;
    cv_d   = 1'b0;
    if (acc) begin
      if (!(state_q == ST_IDLE && is_soh)) sum_d = sum_q + data_i;
      if (is_dig && (state_q == ST_IDLE ||
                     (state_q == ST_TAG && tlen_q == '0)))
        fss_d = sum_q;
      if (state_q == ST_TAG && is_eq && tag_is_8)
        sum_d = sum_q + data_i - fss_q;
      if (state_q == ST_TAG && is_eq && tag_is_10)
        calc_d = fss_q;
      if (state_q == ST_VALUE && is_soh && tag_is_10) begin
        cks_d = calc_q;
        ok_d  = dec_ok && (dec == {2'b00, calc_q});
        cv_d  = 1'b1;
        sum_d = '0;
      end
    end
  end

  // Checksum registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q  <= '0;
      fss_q  <= '0;
      calc_q <= '0;
      cks_q  <= '0;
      ok_q   <= 1'b0;
      cv_q   <= 1'b0;
    end else begin
      sum_q  <= sum_d;
      fss_q  <= fss_d;
      calc_q <= calc_d;
      cks_q  <= cks_d;
      ok_q   <= ok_d;
      cv_q   <= cv_d;
    end
  end

  assign checksum_o       = cks_q;
  assign checksum_ok_o    = ok_q;
  assign checksum_valid_o = cv_q;
`else
  assign checksum_o       = '0;
  assign checksum_ok_o    = 1'b0;
  assign checksum_valid_o = 1'b0;
`endif

endmodule

// File: tb/tb_fix_field_tokenizer.sv
// tb_fix_field_tokenizer: directed and randomised stream checks
// against a field-level reference model.
module tb_fix_field_tokenizer;

  localparam int TB    = 4;
  localparam int VB    = 4;
  localparam int DEPTH = 8;
  localparam int TW    = 8 * TB;
  localparam int VW    = 8 * VB;
  localparam int LW    = $clog2(VB + 1);

  typedef logic [7:0] u8;
  typedef struct {
    logic [TW-1:0] tag;
    logic [VW-1:0] val;
    logic [LW-1:0] len;
    logic          sof;
    logic          eom;
  } ent_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    data = 8'h00;
  logic          dv = 1'b0;
  logic          fr = 1'b0;
  logic          data_ready_o;
  logic [TW-1:0] field_tag_o;
  logic [VW-1:0] field_value_o;
  logic [LW-1:0] field_len_o;
  logic          field_sof_o, field_eom_o, field_valid_o;
  logic          error_o;
  logic [7:0]    checksum_o;
  logic          checksum_valid_o, checksum_ok_o;

  fix_field_tokenizer #(
    .TAG_BYTES   (TB),
    .VALUE_BYTES (VB),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .data_i           (data),
    .data_valid_i     (dv),
    .data_ready_o     (data_ready_o),
    .field_tag_o      (field_tag_o),
    .field_value_o    (field_value_o),
    .field_len_o      (field_len_o),
    .field_sof_o      (field_sof_o),
    .field_eom_o      (field_eom_o),
    .field_valid_o    (field_valid_o),
    .field_ready_i    (fr),
    .error_o          (error_o),
    .checksum_o       (checksum_o),
    .checksum_valid_o (checksum_valid_o),
    .checksum_ok_o    (checksum_ok_o)
  );

  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   err_seen = 0;
  bit   last_acc;
  ent_t expq[$];
  u8    fld[$];
  u8    msg[$];
  bit   in_msg = 0;
  bit   fld_bad = 0;
  int   fstart = 0;
  bit   exp_err = 0, exp_cv = 0, exp_ok = 0;
  u8    exp_cks = 8'h00;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bit is_dig(input u8 b);
    return b >= 8'h30 && b <= 8'h39;
  endfunction

  function automatic int first_eq(input u8 q[$]);
    foreach (q[i]) if (q[i] == 8'h3D) return i;
    return -1;
  endfunction

  function automatic logic [63:0] pack(input u8 q[$], input int lo,
                                       input int hi);
    logic [63:0] v = '0;
    for (int i = lo; i < hi; i++) v = {v[55:0], q[i]};
    return v;
  endfunction

  // A field text is acceptable so far if it reads digit{1..TB}
  // optionally followed by '=' and at most VB value bytes.
  function automatic bit prefix_ok(input u8 q[$]);
    int p  = first_eq(q);
    int nt = (p < 0) ? q.size() : p;
    if (nt > TB) return 0;
    for (int i = 0; i < nt; i++) if (!is_dig(q[i])) return 0;
    if (p == 0) return 0;
    if (p > 0 && (q.size() - p - 1) > VB) return 0;
    return 1;
  endfunction

  task automatic model_step(input bit acc, input u8 b, input bit pop);
    int   p;
    ent_t e;
    logic [63:0] tv;
    exp_err = 0;
    exp_cv  = 0;
    if (pop) void'(expq.pop_front());
    if (!acc) return;
    if (!in_msg && b == 8'h01) return;
    if (!in_msg) begin
      in_msg = 1;
      msg.delete();
      fld.delete();
      fld_bad = 0;
    end
    msg.push_back(b);
    if (b != 8'h01) begin
      if (fld.size() == 0) fstart = msg.size() - 1;
      fld.push_back(b);
      if (!fld_bad) begin
        if (!prefix_ok(fld)) begin
          fld_bad = 1;
          exp_err = 1;
        end else if (b == 8'h3D && first_eq(fld) == fld.size() - 1 &&
                     pack(fld, 0, fld.size() - 1) == 64'h38) begin
          msg = msg[fstart:$];
          fstart = 0;
        end
      end
    end else begin
      if (!fld_bad) begin
        p = first_eq(fld);
        if (p < 0) exp_err = 1;
        else begin
          tv    = pack(fld, 0, p);
          e.tag = TW'(tv);
          e.val = VW'(pack(fld, p + 1, fld.size()));
          e.len = LW'(fld.size() - p - 1);
          e.sof = (tv == 64'h38);
          e.eom = (tv == 64'h3130);
          expq.push_back(e);
          if (e.eom) begin
`ifdef FIX_CHECKSUM_EN
            begin
              u8  s;
              int d;
              s = 8'h00;
              for (int i = 0; i < fstart; i++) s = s + msg[i];
              d = 0;
              for (int i = p + 1; i < fld.size(); i++)
                d = d * 10 + int'(fld[i]) - 48;
              exp_cks = s;
              exp_ok  = (fld.size() - p - 1 == 3) &&
                        is_dig(fld[p+1]) && is_dig(fld[p+2]) &&
                        is_dig(fld[p+3]) && (d == int'(s));
              exp_cv  = 1;
            end
`endif
            in_msg = 0;
          end
        end
      end
      fld.delete();
      fld_bad = 0;
    end
  endtask

  task automatic check_dut();
    chk("data_ready", data_ready_o, expq.size() < DEPTH);
    chk("field_valid", field_valid_o, expq.size() > 0);
    if (expq.size() > 0) begin
      chk("tag", field_tag_o, expq[0].tag);
      chk("value", field_value_o, expq[0].val);
      chk("len", field_len_o, expq[0].len);
      chk("sof", field_sof_o, expq[0].sof);
      chk("eom", field_eom_o, expq[0].eom);
    end
    chk("error", error_o, exp_err);
    chk("cks_valid", checksum_valid_o, exp_cv);
    chk("cks", checksum_o, exp_cks);
    chk("cks_ok", checksum_ok_o, exp_ok);
    if (error_o) err_seen++;
  endtask

  task automatic cycle(input bit v, input u8 b, input bit rdy);
    bit acc, pop;
    check_dut();
    acc  = v && (expq.size() < DEPTH);
    pop  = rdy && (expq.size() > 0);
    dv   = v;
    data = b;
    fr   = rdy;
    model_step(acc, b, pop);
    last_acc = acc;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send_byte(input u8 b, input bit rnd, input bit rdy);
    bit v, r;
    for (int t = 0; t < 64; t++) begin
      v = rnd ? ($urandom % 5 != 0) : 1'b1;
      r = rnd ? ($urandom % 4 != 0) : rdy;
      cycle(v, v ? b : u8'($urandom), r);
      if (last_acc) return;
    end
    n_cmp++;
    n_bad++;
    $display("FAIL stall_timeout: byte %h not accepted in 64 cycles", b);
  endtask

  task automatic send_str(input string s, input bit rdy);
    u8 c;
    for (int i = 0; i < s.len(); i++) begin
      c = s[i];
      send_byte((c == 8'h7C) ? 8'h01 : c, 1'b0, rdy);
    end
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, rdy);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    dv  = 1'b0;
    #1;
    chk("rst_ready", data_ready_o, 1);
    chk("rst_valid", field_valid_o, 0);
    chk("rst_tag", field_tag_o, 0);
    chk("rst_value", field_value_o, 0);
    chk("rst_len", field_len_o, 0);
    chk("rst_flags", {field_sof_o, field_eom_o}, 0);
    chk("rst_err", error_o, 0);
    chk("rst_cks", {checksum_o, checksum_valid_o, checksum_ok_o}, 0);
    expq.delete();
    fld.delete();
    msg.delete();
    in_msg  = 0;
    fld_bad = 0;
    exp_err = 0;
    exp_cv  = 0;
    exp_ok  = 0;
    exp_cks = 8'h00;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_rand_msg();
    u8  s[$];
    u8  sum;
    int cs, tl, vl;
    s = '{8'h38, 8'h3D, 8'h46, 8'h49, 8'h58, 8'h01};
    for (int f = 0; f < $urandom_range(1, 5); f++) begin
      if ($urandom % 8 == 0) begin
        s.push_back(8'h78);
        s.push_back(8'h01);
      end else begin
        tl = $urandom_range(1, 5);
        s.push_back(u8'($urandom_range(50, 57)));
        for (int i = 1; i < tl; i++) s.push_back(u8'(48 + $urandom % 10));
        s.push_back(8'h3D);
        vl = $urandom_range(0, 5);
        for (int i = 0; i < vl; i++) s.push_back(u8'($urandom_range(32, 126)));
        s.push_back(8'h01);
      end
    end
    if ($urandom % 6 == 0) s = {s, 8'h38, 8'h3D, 8'h5A, 8'h01};
    sum = 8'h00;
    foreach (s[i]) sum = sum + s[i];
    cs = ($urandom % 2 == 0) ? int'(sum) : int'($urandom % 256);
    s = {s, 8'h31, 8'h30, 8'h3D};
    if ($urandom % 8 != 0) s.push_back(u8'(48 + cs / 100));
    s.push_back(u8'(48 + (cs / 10) % 10));
    s.push_back(u8'(48 + cs % 10));
    s.push_back(8'h01);
    if ($urandom % 4 == 0) send_byte(8'h01, 1'b1, 1'b0);
    foreach (s[i]) send_byte(s[i], 1'b1, 1'b0);
  endtask

  initial begin
    @(negedge clk);
    do_reset();

    send_str("8=A|10=183|", 1'b0);
    chk("t1_tag", field_tag_o, 32'h38);
    chk("t1_value", field_value_o, 32'h41);
    chk("t1_len", field_len_o, 1);
    chk("t1_sof", field_sof_o, 1);
`ifdef FIX_CHECKSUM_EN
    chk("t1_cks", checksum_o, 8'hB7);
    chk("t1_ok", checksum_ok_o, 1);
    chk("t1_cv", checksum_valid_o, 1);
`else
    chk("t1_no_cv", checksum_valid_o, 0);
`endif
    cycle(1'b0, 8'h00, 1'b1);
    chk("t2_tag", field_tag_o, 32'h3130);
    chk("t2_value", field_value_o, 32'h00313833);
    chk("t2_len", field_len_o, 3);
    chk("t2_eom", field_eom_o, 1);
    idle(2, 1'b1);

    send_str("8=A|10=184|", 1'b1);
`ifdef FIX_CHECKSUM_EN
    chk("t3_cks", checksum_o, 8'hB7);
    chk("t3_ok", checksum_ok_o, 0);
`endif
    idle(2, 1'b1);

    err_seen = 0;
    send_str("12345=X|", 1'b1);
    idle(2, 1'b1);
    chk("tag_ovf_err", err_seen, 1);
    chk("tag_ovf_nopush", field_valid_o, 0);

    err_seen = 0;
    send_str("55=ABCDE|", 1'b1);
    idle(2, 1'b1);
    chk("val_ovf_err", err_seen, 1);
    chk("val_ovf_nopush", field_valid_o, 0);

    send_str("55=ABCD|", 1'b0);
    chk("val_max_tag", field_tag_o, 32'h3535);
    chk("val_max_value", field_value_o, 32'h41424344);
    chk("val_max_len", field_len_o, 4);
    idle(2, 1'b1);

    for (int k = 0; k < DEPTH; k++) send_str("1=a|", 1'b0);
    chk("full_stall", data_ready_o, 0);
    cycle(1'b1, 8'h32, 1'b0);
    cycle(1'b1, 8'h32, 1'b0);
    cycle(1'b1, 8'h32, 1'b1);
    chk("ready_after_pop", data_ready_o, 1);
    send_str("2=b|", 1'b0);
    idle(DEPTH + 2, 1'b1);
    chk("drained", field_valid_o, 0);

    send_str("8=A|55=AB", 1'b1);
    do_reset();
    send_str("8=A|10=183|", 1'b1);
`ifdef FIX_CHECKSUM_EN
    chk("post_rst_cks", checksum_o, 8'hB7);
    chk("post_rst_ok", checksum_ok_o, 1);
`endif
    idle(2, 1'b1);

    for (int m = 0; m < 40; m++) send_rand_msg();
    idle(DEPTH + 4, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
